// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter that shares one N-bit output channel among R = 2^M
// requesters. Each cycle the first requesting input found by scanning from
// the rotating priority pointer is granted. Its word is taken from the packed
// data bus and registered into a single-entry output stage with a
// valid/ready handshake.
//
// Parameters:
//   N  bits per requester word and per output word (default 1)
//   M  selector width; number of requesters R = 2^M (default 1)
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high reset
//   i_req[R]     per-requester request; bit i means word i on i_d is valid
//   i_d[R*N]     packed data; requester i occupies i_d[i*N +: N]
//   o_ack[R]     one-hot combinational accept; bit i means word i taken now
//   o_y[N]       registered output word
//   o_valid      o_y holds an unconsumed word
//   i_ready      downstream accepts o_y this cycle when o_valid is high
//   i_lock       (only with RR_ARB_LOCK_EN) keep the winner at top priority
//   o_grant_idx  registered index of the requester whose word is in o_y
//
// Optional feature: define RR_ARB_LOCK_EN to add i_lock. A load with
// i_lock=1 leaves the winner as the highest-priority requester so it can
// complete a multi-word burst. Without the macro the pointer always moves to
// winner+1.
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int N = 1,
    parameter int M = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [(1<<M)-1:0]       i_req,
    input  logic [(1<<M)*N-1:0]     i_d,
    output logic [(1<<M)-1:0]       o_ack,
    output logic [N-1:0]            o_y,
    output logic                    o_valid,
    input  logic                    i_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic                    i_lock,
`endif
    output logic [M-1:0]            o_grant_idx
);

    localparam int R = 1 << M;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [M-1:0]   r_ptr;
    logic [N-1:0]   r_y;
    logic [M-1:0]   r_grant_idx;

    logic [R-1:0]   w_rot_req;
    logic [N-1:0]   w_word [R];
    logic [M-1:0]   w_offset;
    logic [M-1:0]   w_winner;
    logic [M-1:0]   w_ptr_next;
    logic           w_any_req;
    logic           w_load;

    // w_rot_req[k] is the request of the requester k places after the
    // pointer, so priority becomes a plain lowest-index-first search. The
    // M-bit add wraps modulo R for free.
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_lane
            assign w_rot_req[gi] = i_req[r_ptr + M'(gi)];
            assign w_word[gi]    = i_d[gi*N +: N];
        end
    endgenerate

    // Lowest set bit of the rotated request vector. Scanning downwards lets
    // the last assignment (smallest offset) win without a found flag.
    always_comb begin
        w_offset = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (w_rot_req[k]) begin
                w_offset = M'(k);
            end
        end
    end

    assign w_winner  = r_ptr + w_offset;
    assign w_any_req = |i_req;

    // Reset is folded in so no requester sees an accept for a word that the
    // reset is about to throw away.
    assign w_load = ((r_state == ST_EMPTY) || i_ready) && w_any_req && !i_reset;

`ifdef RR_ARB_LOCK_EN
    assign w_ptr_next = i_lock ? w_winner : (w_winner + M'(1));
`else
    assign w_ptr_next = w_winner + M'(1);
`endif

    // Output-stage next state and the one-hot accept.
    always_comb begin
        w_state_next = r_state;
        o_ack        = '0;
        if (w_load) begin
            o_ack[w_winner] = 1'b1;
        end
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                // A load while full is the back-to-back case and stays FULL.
                if (i_ready && !w_load) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_EMPTY;
            r_ptr       <= '0;
            r_y         <= '0;
            r_grant_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_y         <= w_word[w_winner];
                r_grant_idx <= w_winner;
                r_ptr       <= w_ptr_next;
            end
        end
    end

    assign o_y         = r_y;
    assign o_valid     = (r_state == ST_FULL);
    assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Directed bench for rr_mux_arbiter with M=2 (four requesters) and N=8.
// Inputs are driven 1 ns after the rising edge; outputs are sampled 1 ns
// later, well away from the next edge. Expected values are hand-derived from
// the round-robin rules. Build with RR_ARB_LOCK_EN defined to also cover the
// lock sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

    localparam int N = 8;
    localparam int M = 2;
    localparam int R = 1 << M;

    logic               clk;
    logic               reset;
    logic [R-1:0]       req;
    logic [R*N-1:0]     d;
    logic [R-1:0]       ack;
    logic [N-1:0]       y;
    logic               valid;
    logic               ready;
    logic               lock;
    logic [M-1:0]       grant_idx;

    int n_tests;
    int n_fail;

    rr_mux_arbiter #(.N(N), .M(M)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_d         (d),
        .o_ack       (ack),
        .o_y         (y),
        .o_valid     (valid),
        .i_ready     (ready),
`ifdef RR_ARB_LOCK_EN
        .i_lock      (lock),
`endif
        .o_grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] exp_y,
                             input logic exp_valid, input logic [M-1:0] exp_grant);
        check_eq({tag, "_y"},     32'(y),         32'(exp_y));
        check_eq({tag, "_valid"}, 32'(valid),     32'(exp_valid));
        check_eq({tag, "_grant"}, 32'(grant_idx), 32'(exp_grant));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        req     = '0;
        d       = 32'h4433_2211;
        ready   = 1'b1;
        lock    = 1'b0;

        cyc();
        cyc();

        // Accept must stay low while reset is asserted, even with requests.
        req = 4'b1111;
        #1;
        check_eq("ack_in_reset", 32'(ack), 32'h0);
        cyc();

        // Rotation with all four requesting: ptr 0 -> 1 -> 2 -> 3 -> 0.
        reset = 1'b0;
        #1;
        check_out("post_reset", 8'h00, 1'b0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                check_out($sformatf("rot%0d", k), 8'(8'h11 * ((k - 1) % 4 + 1)),
                          1'b1, M'((k - 1) % 4));
            end
            check_eq($sformatf("rot%0d_ack", k), 32'(ack), 32'(1 << (k % 4)));
            cyc();
        end
        // ptr = 1 now; last word loaded was requester 0.

        // Wrap-around: grant 2 (ptr -> 3), then req 1001 gives 3, then 0.
        req = 4'b0100;
        #1;
        check_out("rot5", 8'h11, 1'b1, 2'd0);
        check_eq("wrap_g2_ack", 32'(ack), 32'b0100);
        cyc();
        req = 4'b1001;
        #1;
        check_eq("wrap_g3_ack", 32'(ack), 32'b1000);
        cyc();
        #1;
        check_out("wrap_g3", 8'h44, 1'b1, 2'd3);
        check_eq("wrap_g0_ack", 32'(ack), 32'b0001);
        cyc();
        // ptr must be 1: with req 0011 requester 1 wins over 0.
        req = 4'b0011;
        #1;
        check_eq("wrap_ptr1_ack", 32'(ack), 32'b0010);
        cyc();

        // Backpressure: full and not ready. Word 1 changes on d meanwhile,
        // which must not reach y until a fresh load.
        ready = 1'b0;
        req   = 4'b0010;
        d     = 32'h4433_5A11;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("bp%0d_ack", k), 32'(ack), 32'h0);
            check_out($sformatf("bp%0d", k), 8'h22, 1'b1, 2'd1);
            cyc();
        end
        ready = 1'b1;
        #1;
        check_eq("bp_release_ack", 32'(ack), 32'b0010);
        cyc();
        #1;
        check_out("bp_release", 8'h5A, 1'b1, 2'd1);

        // Drain: ready with no requests empties the stage, y is kept.
        req = '0;
        #1;
        check_eq("drain_ack", 32'(ack), 32'h0);
        cyc();
        #1;
        check_out("drain", 8'h5A, 1'b0, 2'd1);

        // Empty stage loads even when ready is low. ptr is 2.
        ready = 1'b0;
        req   = 4'b0100;
        #1;
        check_eq("empty_load_ack", 32'(ack), 32'b0100);
        cyc();
        #1;
        check_out("empty_load", 8'h33, 1'b1, 2'd2);

        // Put 8'h22 into y (ptr 3 -> requester 1 wins, ptr -> 2).
        ready = 1'b1;
        req   = 4'b0010;
        d     = 32'h4433_2211;
        #1;
        check_eq("pre_rst_ack", 32'(ack), 32'b0010);
        cyc();
        #1;
        check_out("pre_rst", 8'h22, 1'b1, 2'd1);

        // Reset mid-transfer.
        reset = 1'b1;
        req   = 4'b1111;
        #1;
        check_eq("mid_rst_ack", 32'(ack), 32'h0);
        cyc();
        reset = 1'b0;
        #1;
        check_out("mid_rst_after", 8'h00, 1'b0, 2'd0);
        check_eq("mid_rst_first_ack", 32'(ack), 32'b0001);
        cyc();
        #1;
        check_out("mid_rst_first", 8'h11, 1'b1, 2'd0);
        // ptr = 1 now.

`ifdef RR_ARB_LOCK_EN
        req  = 4'b0110;
        lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("lock%0d_ack", k), 32'(ack), 32'b0010);
            cyc();
        end
        lock = 1'b0;
        #1;
        check_eq("unlock0_ack", 32'(ack), 32'b0010);
        cyc();
        #1;
        check_eq("unlock1_ack", 32'(ack), 32'b0100);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
